// File: rtl/soundrive_i2s.sv
// soundrive_i2s: mixes the four Soundrive DAC latches into a 16-bit I2S stream with its own sck/lrck
module soundrive_i2s #(
    parameter int DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mute,
    input  logic [7:0] l1,
    input  logic [7:0] l2,
    input  logic [7:0] r1,
    input  logic [7:0] r2,
    output logic       sck,
    output logic       lrck,
    output logic       sdo,
    output logic       sample
);
    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
    logic [7:0]  div_q, div_d;
    logic        sck_q, sck_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic        lrck_q, lrck_d;
    logic        sample_q, sample_d;
    logic [31:0] shift_q, shift_d;
    logic [15:0] right_q, right_d;
    logic        wrap, fall, start, mid;
    logic [8:0]  suml, sumr;
    logic [15:0] left_s, right_s;
    // bit-clock divider: sck toggles on every divider wrap, falling edges drive the frame
    always_comb begin
        wrap  = div_q == DIV_M1;
        fall  = wrap && sck_q;
        div_d = wrap ? 8'd0 : div_q + 8'd1;
        sck_d = wrap ? ~sck_q : sck_q;
    end
    // slot position: bitcnt advances on falls, lrck follows its top bit
    always_comb begin
        bitcnt_d = fall ? bitcnt_q + 6'd1 : bitcnt_q;
        lrck_d   = fall ? bitcnt_d[5] : lrck_q;
        start    = fall && bitcnt_d == 6'd0;
        mid      = fall && bitcnt_d == 6'd32;
        sample_d = start;
    end
    // mixing: offset-binary sum becomes signed by inverting its top bit
    always_comb begin
        suml    = {1'b0, l1} + {1'b0, l2};
        sumr    = {1'b0, r1} + {1'b0, r2};
        left_s  = mute ? 16'h0000 : {~suml[8], suml[7:0], 7'b0};
        right_s = mute ? 16'h0000 : {~sumr[8], sumr[7:0], 7'b0};
    end
    // shifter: the leading zero slot bit gives the I2S one-bit delay
    always_comb begin
        right_d = start ? right_s : right_q;
        shift_d = start ? {1'b0, left_s, 15'b0}
                : mid   ? {1'b0, right_q, 15'b0}
                : fall  ? {shift_q[30:0], 1'b0}
                : shift_q;
    end
    // state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q    <= 8'd0;
            sck_q    <= 1'b0;
            bitcnt_q <= 6'd63;
            lrck_q   <= 1'b1;
            sample_q <= 1'b0;
            shift_q  <= 32'd0;
            right_q  <= 16'd0;
        end else begin
            div_q    <= div_d;
            sck_q    <= sck_d;
            bitcnt_q <= bitcnt_d;
            lrck_q   <= lrck_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            right_q  <= right_d;
        end
    end
    assign sck    = sck_q;
    assign lrck   = lrck_q;
    assign sdo    = shift_q[31];
    assign sample = sample_q;
endmodule

// File: tb/tb_soundrive_i2s.sv
// tb_soundrive_i2s: directed vector bench for the Soundrive I2S serialiser
module tb_soundrive_i2s;
    localparam int DIV = 4;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mute = 1'b0;
    logic [7:0] l1 = 8'h80, l2 = 8'h80, r1 = 8'h80, r2 = 8'h80;
    logic       sck, lrck, sdo, sample;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        logic [7:0]  l1, l2, r1, r2;
        logic        mute;
        logic [15:0] el, er;
    } vec_t;
    vec_t vecs[6];

    soundrive_i2s #(.DIV(DIV)) dut (
        .clock(clock), .reset(reset), .mute(mute),
        .l1(l1), .l2(l2), .r1(r1), .r2(r2),
        .sck(sck), .lrck(lrck), .sdo(sdo), .sample(sample)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic get_frame(output logic [15:0] lw, output logic [15:0] rw,
                             output logic zok, output logic lok,
                             input int chg_at, input logic [7:0] chg_val);
        int t = 0;
        int q;
        step();
        while (!sample && t < 200 * DIV) begin
            step();
            t++;
        end
        if (!sample) chk("frame_start_timeout", 32'd0, 32'd1);
        lw = 16'd0;
        rw = 16'd0;
        zok = 1'b1;
        lok = 1'b1;
        for (int p = 0; p < 64; p++) begin
            q = p % 32;
            if (lrck !== (p >= 32)) lok = 1'b0;
            if (q >= 1 && q <= 16) begin
                if (p < 32) lw[16-q] = sdo;
                else        rw[16-q] = sdo;
            end else if (sdo !== 1'b0) zok = 1'b0;
            if (p == chg_at) l1 = chg_val;
            if (p < 63) repeat (2 * DIV) step();
        end
    endtask

    initial begin
        logic [15:0] lw, rw;
        logic        zok, lok, sck_ok, smp_ok, hold_ok;
        int          k;
        vecs[0] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 16'h7F00, 16'h8000};
        vecs[2] = '{8'h01, 8'h00, 8'h80, 8'h81, 1'b0, 16'h8080, 16'h0080};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 16'h0000, 16'h0000};
        vecs[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 16'h8000, 16'h7F00};
        vecs[5] = '{8'h40, 8'h20, 8'hC0, 8'h80, 1'b0, 16'hB000, 16'h2000};

        repeat (3) step();
        chk("reset_outputs", {28'd0, sck, lrck, sdo, sample}, {28'd0, 4'b0100});
        reset = 1'b0;
        sck_ok = 1'b1;
        smp_ok = 1'b1;
        hold_ok = 1'b1;
        for (int c = 1; c <= 2 * DIV; c++) begin
            step();
            if (sck !== (c >= DIV && c < 2 * DIV)) sck_ok = 1'b0;
            if (sample !== (c == 2 * DIV)) smp_ok = 1'b0;
            if (c < 2 * DIV && (lrck !== 1'b1 || sdo !== 1'b0)) hold_ok = 1'b0;
        end
        chk("startup_sck", {31'd0, sck_ok}, 32'd1);
        chk("startup_sample", {31'd0, smp_ok}, 32'd1);
        chk("startup_hold", {31'd0, hold_ok}, 32'd1);
        chk("first_frame_start", {30'd0, lrck, sdo}, 32'd0);
        k = 0;
        do begin
            step();
            k++;
        end while (!sample && k < 1000);
        chk("sample_period", k, 128 * DIV);

        for (int i = 0; i < 6; i++) begin
            l1 = vecs[i].l1;
            l2 = vecs[i].l2;
            r1 = vecs[i].r1;
            r2 = vecs[i].r2;
            mute = vecs[i].mute;
            get_frame(lw, rw, zok, lok, -1, 8'h00);
            chk($sformatf("vec%0d_left", i), {16'd0, lw}, {16'd0, vecs[i].el});
            chk($sformatf("vec%0d_right", i), {16'd0, rw}, {16'd0, vecs[i].er});
            chk($sformatf("vec%0d_pad_zero", i), {31'd0, zok}, 32'd1);
            chk($sformatf("vec%0d_lrck", i), {31'd0, lok}, 32'd1);
        end

        mute = 1'b0;
        l1 = 8'h80; l2 = 8'h80; r1 = 8'h80; r2 = 8'h80;
        get_frame(lw, rw, zok, lok, 10, 8'hFF);
        chk("midchg_cur_left", {16'd0, lw}, 32'h0000);
        chk("midchg_cur_right", {16'd0, rw}, 32'h0000);
        get_frame(lw, rw, zok, lok, -1, 8'h00);
        chk("midchg_next_left", {16'd0, lw}, 32'h3F80);
        chk("midchg_next_right", {16'd0, rw}, 32'h0000);

        step();
        k = 0;
        while (!sample && k < 200 * DIV) begin
            step();
            k++;
        end
        repeat (40 * 2 * DIV) step();
        chk("pre_reset_lrck", {31'd0, lrck}, 32'd1);
        reset = 1'b1;
        step();
        chk("midframe_reset_outputs", {28'd0, sck, lrck, sdo, sample}, {28'd0, 4'b0100});
        reset = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (!sample && k < 1000);
        chk("post_reset_first_sample", k, 2 * DIV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/soundrive_i2s.md
# soundrive_i2s

Serialises the four Soundrive DAC latches (two left, two right, 8-bit unsigned, midscale 0x80) into a standard I2S stream for an external audio codec. Each channel pair is summed, converted to signed 16-bit and shifted out MSB-first in 32-bit slots. The block sits on the consuming side of the Soundrive port latches. It generates its own bit clock and word clock from the system clock.

## Interface
- DIV, 4: system clocks per half period of sck; legal range 1..255.

- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- mute  in  1  when high at capture, both captured samples are forced to 0x0000
- l1  in  8  left DAC A, unsigned
- l2  in  8  left DAC B, unsigned
- r1  in  8  right DAC A, unsigned
- r2  in  8  right DAC B, unsigned
- sck  out  1  I2S bit clock
- lrck  out  1  I2S word select; 0 = left slot, 1 = right slot
- sdo  out  1  I2S serial data
- sample  out  1  one-clock pulse on the clock where a new L/R pair is captured

## Operation
- **Mixing.** `suml = l1 + l2` and `sumr = r1 + r2`, each 9-bit unsigned.
  - Signed sample = `{~sum[8], sum[7:0], 7'b0}`.
  - 0 → 0x8000, 256 → 0x0000, 510 → 0x7F00. No saturation is needed.
- **Divider.** `div` counts 0..DIV-1 and wraps. On each wrap clock, sck toggles.
- **Fall event.** A clock with a wrap while sck=1. All of the following update on that same clock, together with sck going to 0:
  - `bitcnt` (6-bit): increments, wrapping 63→0.
  - `lrck`: becomes the new `bitcnt[5]`.
  - `sdo`: updates from the shift register.
- **New bitcnt = 0 (frame start).**
  - Capture left and right samples from the current inputs and mute. Mute gives 0x0000 for both.
  - Pulse `sample` for that one clock.
  - Load the 32-bit shift register with `{1'b0, left, 15'b0}`. Hold the right sample in a register.
- **New bitcnt = 32.** Load the shift register with `{1'b0, right_held, 15'b0}`.
- **Other fall events.** Shift left by 1, filling with 0.
- **sdo.** Always equals the shift register MSB. Consequences:
  - Slot position p=0 carries 0 (I2S one-bit delay).
  - p=1..16 carry sample bits 15..0.
  - p=17..31 carry 0.
- **Input sampling.** Inputs are read only at frame start. Changes mid-frame take effect at the next frame. Left and right of one frame always come from the same clock.
- **Reset values.** Reset overrides everything on the clock it is seen.
  - sck=0, div=0, bitcnt=63, lrck=1, sdo=0, sample=0.
  - Shift register and held right sample = 0.

## Timing
- sck period = 2·DIV clocks, with 50% duty.
- Frame = 64 sck periods = 128·DIV clocks.
- sck first rises on the DIV-th clock after reset deasserts, and first falls on the 2·DIV-th clock. That first fall is the first frame start: bitcnt=0, lrck=0, sample=1, sdo=0.
- lrck and sdo change only on fall-event clocks, so they are stable for DIV clocks before and after every sck rise.
- Input-to-output latency:
  - Left MSB appears on sdo one sck period after capture.
  - Right MSB appears 33 sck periods after capture.
- `sample` is high for exactly 1 clock per frame, every 128·DIV clocks.
- Reset asserted mid-frame:
  - Outputs go to reset values on the next clock edge.
  - The partial frame is discarded with no further sample pulse.
  - Timing restarts as from power-up after deassertion.
- DIV=1: sck toggles every clock; behaviour is otherwise identical.

## Test plan
- **Reset/startup, DIV=4.** Release reset → sck=0, lrck=1, sdo=0 held; sck rises at clock 4, falls at clock 8; sample=1 only on clock 8; then sample period = 512 clocks.
- **Midscale.** l1=l2=r1=r2=0x80 → sdo=0 for all 64 bits of every frame; lrck low for bits 0..31, high for bits 32..63.
- **Extremes.** l1=l2=0xFF, r1=r2=0x00 → left bits p1..p16 decode 0x7F00, right bits decode 0x8000; p0 and p17..p31 are 0 in both slots.
- **Asymmetric.** l1=0x01, l2=0x00, r1=0x80, r2=0x81 → left 0x8080, right 0x0080.
- **Mid-frame change and mute.** Change l1 at bitcnt=10 → current frame unchanged, next frame shows new value. Assert mute before a frame start → that frame is all-zero sdo.
- **Reset mid-frame.** Assert reset at bitcnt=40 for 1 clock → next clock has reset values; next sample pulse comes exactly 2·DIV clocks after deassertion.
